// File: rtl/lexington_pkg.sv
// Writeback-unit configuration shared by the top and its queue.
// Default load-queue depth and its index type.
package lexington;
  localparam int unsigned LOAD_DEPTH_DEF = 4;
  localparam int unsigned QIDX_W = $clog2(LOAD_DEPTH_DEF);
  typedef logic [QIDX_W-1:0] qidx_t;
endpackage

// File: rtl/rv32_pkg.sv
// RV32 base types shared across the core.
// Architectural word and register-index widths.
package rv32;
  typedef logic [31:0] word;
  typedef logic [4:0]  gpr_addr_t;
endpackage

// File: rtl/addr_fifo.sv
// In-order FIFO of pending load destinations.
// Exposes per-entry valid/data so operands can be scoreboarded.
module addr_fifo
  import rv32::*;
#(
  parameter  int unsigned DEPTH = lexington::LOAD_DEPTH_DEF,
  localparam int unsigned PW    = $clog2(DEPTH),
  localparam int unsigned CW    = PW + 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push,
  input  gpr_addr_t               push_data,
  input  logic                    pop,
  output gpr_addr_t               head,
  output logic                    full,
  output logic                    empty,
  output logic [CW-1:0]           count,
  output logic [DEPTH-1:0]        ent_valid,
  output gpr_addr_t [DEPTH-1:0]   ent_data
);

  logic [PW-1:0] wr_q, wr_d;
  logic [PW-1:0] rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  gpr_addr_t [DEPTH-1:0] mem_q, mem_d;
  logic do_push, do_pop;

  assign empty    = (cnt_q == '0);
  assign full     = (cnt_q == CW'(DEPTH));
  assign count    = cnt_q;
  assign head     = mem_q[rd_q];
  assign ent_data = mem_q;

  // A pop frees the head slot, so a full queue can still take a push.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    mem_d = mem_q;
    if (do_push) begin
      mem_d[wr_q] = push_data;
      wr_d = wr_q + 1'b1;
    end
    if (do_pop) begin
      rd_d = rd_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_comb begin
    ent_valid = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ent_valid[i] = {1'b0, PW'(i) - rd_q} < cnt_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      mem_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
      mem_q <= mem_d;
    end
  end

endmodule

// File: rtl/writeback_unit.sv
// Register-file writeback arbiter: ALU results and in-order load returns.
// Tracks pending load destinations for operand hazard checks.
module writeback_unit
  import rv32::*, lexington::*;
#(
  parameter int unsigned LOAD_DEPTH = LOAD_DEPTH_DEF
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      alu_valid,
  input  gpr_addr_t alu_dest,
  input  word       alu_data,
  input  logic      load_issue,
  input  gpr_addr_t load_dest,
  input  logic      mem_rsp_valid,
  input  word       mem_rsp_data,
  output logic      mem_rsp_ready,
  input  gpr_addr_t rs1_addr,
  input  gpr_addr_t rs2_addr,
  output logic      rs1_busy,
  output logic      rs2_busy,
  output logic      load_full,
  output logic      load_empty,
  output logic      hazard_err,
  output logic      dest_en,
  output gpr_addr_t dest_addr,
  output word       dest_data
);

  localparam int unsigned CW = $clog2(LOAD_DEPTH) + 1;

  gpr_addr_t q_head;
  logic q_full, q_empty;
  logic [CW-1:0] q_count;
  logic [LOAD_DEPTH-1:0] q_valid;
  gpr_addr_t [LOAD_DEPTH-1:0] q_data;

  logic rsp_pop;
  logic rs1_hit, rs2_hit, waw_hit;
  logic drop, stray, waw;

  logic en_q, en_d;
  gpr_addr_t addr_q, addr_d;
  word data_q, data_d;
  logic err_q, err_d;

  addr_fifo #(.DEPTH(LOAD_DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (load_issue),
    .push_data (load_dest),
    .pop       (rsp_pop),
    .head      (q_head),
    .full      (q_full),
    .empty     (q_empty),
    .count     (q_count),
    .ent_valid (q_valid),
    .ent_data  (q_data)
  );

  // ALU owns the write port whenever it has a result.
  assign mem_rsp_ready = !alu_valid && !q_empty;
  assign rsp_pop       = mem_rsp_valid && mem_rsp_ready;
  assign load_full     = q_full;
  assign load_empty    = q_empty;

  always_comb begin
    rs1_hit = 1'b0;
    rs2_hit = 1'b0;
    waw_hit = 1'b0;
    for (int i = 0; i < LOAD_DEPTH; i++) begin
      if (q_valid[i]) begin
        rs1_hit = rs1_hit | (q_data[i] == rs1_addr);
        rs2_hit = rs2_hit | (q_data[i] == rs2_addr);
        waw_hit = waw_hit | (q_data[i] == alu_dest);
      end
    end
  end

  assign rs1_busy = rs1_hit && (rs1_addr != '0);
  assign rs2_busy = rs2_hit && (rs2_addr != '0);

  assign drop  = load_issue && (q_count == CW'(LOAD_DEPTH)) && !rsp_pop;
  assign stray = mem_rsp_valid && q_empty;
  assign waw   = alu_valid && (alu_dest != '0) && waw_hit;

  always_comb begin
    en_d   = 1'b0;
    addr_d = addr_q;
    data_d = data_q;
    err_d  = drop | stray | waw;
    unique case (1'b1)
      alu_valid: begin
        en_d   = (alu_dest != '0);
        addr_d = alu_dest;
        data_d = alu_data;
      end
      rsp_pop: begin
        en_d   = (q_head != '0);
        addr_d = q_head;
        data_d = mem_rsp_data;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      err_q  <= 1'b0;
    end else begin
      en_q   <= en_d;
      addr_q <= addr_d;
      data_q <= data_d;
      err_q  <= err_d;
    end
  end

  assign dest_en    = en_q;
  assign dest_addr  = addr_q;
  assign dest_data  = data_q;
  assign hazard_err = err_q;

endmodule

// File: tb/tb_writeback_unit.sv
// Bench for writeback_unit: queue-based reference model checked every
// negedge, plus directed scenarios with literal expectations.
module tb_writeback_unit;
  import rv32::*;

  localparam int LD = 4;

  logic      clk = 1'b0;
  logic      rst_n;
  logic      alu_valid;
  gpr_addr_t alu_dest;
  word       alu_data;
  logic      load_issue;
  gpr_addr_t load_dest;
  logic      mem_rsp_valid;
  word       mem_rsp_data;
  logic      mem_rsp_ready;
  gpr_addr_t rs1_addr, rs2_addr;
  logic      rs1_busy, rs2_busy;
  logic      load_full, load_empty;
  logic      hazard_err;
  logic      dest_en;
  gpr_addr_t dest_addr;
  word       dest_data;

  int checks = 0;
  int errors = 0;

  writeback_unit #(.LOAD_DEPTH(LD)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .alu_valid     (alu_valid),
    .alu_dest      (alu_dest),
    .alu_data      (alu_data),
    .load_issue    (load_issue),
    .load_dest     (load_dest),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_data  (mem_rsp_data),
    .mem_rsp_ready (mem_rsp_ready),
    .rs1_addr      (rs1_addr),
    .rs2_addr      (rs2_addr),
    .rs1_busy      (rs1_busy),
    .rs2_busy      (rs2_busy),
    .load_full     (load_full),
    .load_empty    (load_empty),
    .hazard_err    (hazard_err),
    .dest_en       (dest_en),
    .dest_addr     (dest_addr),
    .dest_data     (dest_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pending destinations as a plain queue.
  gpr_addr_t mq[$];
  logic m_en = 1'b0;
  gpr_addr_t m_addr = '0;
  word m_data = '0;
  logic m_err = 1'b0;

  function automatic logic pending(input gpr_addr_t a);
    if (a == 0) return 1'b0;
    foreach (mq[i]) if (mq[i] == a) return 1'b1;
    return 1'b0;
  endfunction

  always @(negedge clk) begin
    logic e_empty, e_full, e_ready, pop;
    if (!rst_n) begin
      mq.delete();
      m_en = 1'b0; m_addr = '0; m_data = '0; m_err = 1'b0;
    end
    chk("cmp_dest_en", dest_en, m_en);
    chk("cmp_dest_addr", dest_addr, m_addr);
    chk("cmp_dest_data", dest_data, m_data);
    chk("cmp_hazard_err", hazard_err, m_err);
    e_empty = (mq.size() == 0);
    e_full  = (mq.size() == LD);
    e_ready = !alu_valid && !e_empty;
    chk("cmp_empty", load_empty, e_empty);
    chk("cmp_full", load_full, e_full);
    chk("cmp_ready", mem_rsp_ready, e_ready);
    chk("cmp_rs1_busy", rs1_busy, pending(rs1_addr));
    chk("cmp_rs2_busy", rs2_busy, pending(rs2_addr));
    if (rst_n) begin
      pop = mem_rsp_valid && e_ready;
      m_err = (load_issue && e_full && !pop) || (mem_rsp_valid && e_empty)
              || (alu_valid && pending(alu_dest));
      if (alu_valid) begin
        m_en = (alu_dest != 0); m_addr = alu_dest; m_data = alu_data;
      end else if (pop) begin
        m_en = (mq[0] != 0); m_addr = mq[0]; m_data = mem_rsp_data;
      end else begin
        m_en = 1'b0;
      end
      if (pop) void'(mq.pop_front());
      if (load_issue && mq.size() < LD) mq.push_back(load_dest);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set(input logic av, input gpr_addr_t ad, input word dat,
                     input logic li, input gpr_addr_t ld,
                     input logic rv, input word rd);
    alu_valid = av; alu_dest = ad; alu_data = dat;
    load_issue = li; load_dest = ld;
    mem_rsp_valid = rv; mem_rsp_data = rd;
  endtask

  task automatic idle();
    set(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic issue(input gpr_addr_t d);
    set(0, 0, 0, 1, d, 0, 0);
    tick();
  endtask

  task automatic rsp(input word d);
    set(0, 0, 0, 0, 0, 1, d);
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    rs1_addr = '0; rs2_addr = '0;
    idle();
    tick(); tick();
    chk("rst_empty", load_empty, 1);
    chk("rst_full", load_full, 0);
    chk("rst_en", dest_en, 0);
    chk("rst_err", hazard_err, 0);
    rst_n = 1'b1;

    set(1, 5, 32'hDEADBEEF, 0, 0, 0, 0);
    tick();
    chk("alu_en", dest_en, 1);
    chk("alu_addr", dest_addr, 5);
    chk("alu_data", dest_data, 32'hDEADBEEF);
    idle();
    tick();
    chk("idle_en", dest_en, 0);
    chk("idle_hold", dest_data, 32'hDEADBEEF);

    issue(3);
    issue(7);
    idle();
    rs1_addr = 7; rs2_addr = 3;
    #1;
    chk("rs1_busy_x7", rs1_busy, 1);
    chk("rs2_busy_x3", rs2_busy, 1);
    tick();
    rsp(32'h11);
    chk("ld1_addr", dest_addr, 3);
    chk("ld1_data", dest_data, 32'h11);
    chk("rs2_free", rs2_busy, 0);
    rsp(32'h22);
    chk("ld2_addr", dest_addr, 7);
    chk("ld2_data", dest_data, 32'h22);
    chk("ld_empty", load_empty, 1);

    issue(4);
    set(1, 9, 32'h99, 0, 0, 1, 32'h33);
    #1;
    chk("alu_prio_ready", mem_rsp_ready, 0);
    tick();
    chk("alu_prio_addr", dest_addr, 9);
    set(0, 0, 0, 0, 0, 1, 32'h33);
    #1;
    chk("rsp_after_ready", mem_rsp_ready, 1);
    tick();
    chk("rsp_after_addr", dest_addr, 4);
    chk("rsp_after_data", dest_data, 32'h33);

    issue(1); issue(2); issue(3); issue(4);
    chk("full4", load_full, 1);
    rs2_addr = 4;
    set(0, 0, 0, 1, 5, 1, 32'hA1);
    #1;
    chk("full_rs2_busy", rs2_busy, 1);
    tick();
    chk("pushpop_err", hazard_err, 0);
    chk("pushpop_full", load_full, 1);
    chk("pushpop_addr", dest_addr, 1);
    issue(6);
    chk("overflow_err", hazard_err, 1);
    rsp(32'hB2);
    chk("drain_err_clr", hazard_err, 0);
    chk("drain2", dest_addr, 2);
    rsp(32'hB3);
    rsp(32'hB4);
    rsp(32'hB5);
    chk("drain5_addr", dest_addr, 5);
    chk("drain5_data", dest_data, 32'hB5);
    chk("dropped_empty", load_empty, 1);
    rsp(32'hEE);
    chk("stray_err", hazard_err, 1);
    chk("stray_en", dest_en, 0);

    issue(8);
    set(1, 8, 32'h88, 0, 0, 0, 0);
    tick();
    chk("waw_en", dest_en, 1);
    chk("waw_err", hazard_err, 1);
    rsp(32'h80);
    chk("waw_ld_addr", dest_addr, 8);

    issue(0);
    rs1_addr = 0;
    idle();
    #1;
    chk("x0_not_busy", rs1_busy, 0);
    rsp(32'h55);
    chk("x0_ld_en", dest_en, 0);
    chk("x0_empty", load_empty, 1);
    set(1, 0, 32'h77, 0, 0, 0, 0);
    tick();
    chk("x0_alu_en", dest_en, 0);

    issue(10); issue(11); issue(12);
    idle();
    rst_n = 1'b0;
    #1;
    chk("arst_empty", load_empty, 1);
    chk("arst_full", load_full, 0);
    chk("arst_en", dest_en, 0);
    chk("arst_addr", dest_addr, 0);
    chk("arst_data", dest_data, 0);
    chk("arst_err", hazard_err, 0);
    tick();
    rst_n = 1'b1;
    set(0, 0, 0, 0, 0, 1, 32'h99);
    #1;
    chk("post_rst_ready", mem_rsp_ready, 0);
    tick();
    chk("post_rst_err", hazard_err, 1);
    idle();
    tick(); tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/writeback_unit.md
WRITEBACK_UNIT -- requirements
Module: writeback_unit

Interface
REQ-001 Parameter LOAD_DEPTH, default 4, SHALL set the number of outstanding loads tracked (power of two, 2..8).
REQ-002 Port list: clk, input, 1, rising-edge clock; one clock, all state on clk.
REQ-003 Port list: rst_n, input, 1, asynchronous active-low reset.
REQ-004 Port list: alu_valid, input, 1, ALU result valid this cycle.
REQ-005 Port list: alu_dest, input, rv32::gpr_addr_t, ALU destination register.
REQ-006 Port list: alu_data, input, rv32::word, ALU result.
REQ-007 Port list: load_issue, input, 1, load issued to memory this cycle.
REQ-008 Port list: load_dest, input, rv32::gpr_addr_t, issued load destination.
REQ-009 Port list: mem_rsp_valid, input, 1, load data returning (in issue order).
REQ-010 Port list: mem_rsp_data, input, rv32::word, returned load data.
REQ-011 Port list: mem_rsp_ready, output, 1, response accepted when valid&&ready.
REQ-012 Port list: rs1_addr and rs2_addr, input, rv32::gpr_addr_t, operands to check for hazards.
REQ-013 Port list: rs1_busy and rs2_busy, output, 1 each, operand has a pending load.
REQ-014 Port list: load_full and load_empty, output, 1 each, pending-load queue status.
REQ-015 Port list: hazard_err, output, 1, registered one-cycle error pulse.
REQ-016 Port list: dest_en, output, 1, register-file write enable.
REQ-017 Port list: dest_addr, output, rv32::gpr_addr_t, register-file write address.
REQ-018 Port list: dest_data, output, rv32::word, register-file write data.

Function
REQ-019 Pending-load queue SHALL be a LOAD_DEPTH-entry in-order FIFO of destination addresses; load_issue pushes load_dest, accepted response pops head.
REQ-020 mem_rsp_ready SHALL equal !alu_valid && !load_empty; ALU has absolute write-port priority.
REQ-021 Write port SHALL be registered: the winning source in cycle N drives dest_en/addr/data in cycle N+1; if neither source wins, dest_en=0 and addr/data hold.
REQ-022 dest_en SHALL be 0 for any write to x0; a load to x0 still occupies and pops a queue entry.
REQ-023 rsN_busy SHALL be combinational: 1 iff rsN_addr!=0 and any valid queue entry matches rsN_addr, including the head being popped this cycle.
REQ-024 Simultaneous push and pop SHALL be legal at any occupancy including full: count unchanged, pointers advance.
REQ-025 load_issue while full without same-cycle pop SHALL be dropped and pulse hazard_err next cycle.
REQ-026 mem_rsp_valid while load_empty SHALL be ignored (ready=0) and pulse hazard_err next cycle.
REQ-027 alu_valid with alu_dest!=0 matching a valid queue entry (WAW) SHALL still write and pulse hazard_err next cycle.
REQ-028 Pointers SHALL wrap modulo LOAD_DEPTH; load_full and load_empty SHALL derive from a count of width clog2(LOAD_DEPTH)+1.

Reset
REQ-029 rst_n low SHALL immediately force: queue empty, load_empty=1, load_full=0, dest_en=0, dest_addr=0, dest_data=0, hazard_err=0.
REQ-030 Reset mid-operation SHALL discard all pending entries; responses arriving after reset release are treated as per REQ-026.

Structure
REQ-031 LOAD_DEPTH default and a queue-index type SHALL live in package lexington; word and gpr_addr_t types come from rv32.
REQ-032 The address FIFO SHALL be a sub-module addr_fifo (push/pop/full/empty/count plus entry-valid and entry-data vectors for REQ-023).

Verification
REQ-033 Reset, then alu_valid, dest=5, data=0xDEADBEEF -> next cycle dest_en=1, addr=5, data=0xDEADBEEF.
REQ-034 Issue loads to x3 and x7; rs1_addr=7 -> rs1_busy=1; responses 0x11 then 0x22 -> writes x3=0x11, then x7=0x22; load_empty=1 afterwards.
REQ-035 One pending load plus mem_rsp_valid and alu_valid (dest=9) in the same cycle -> mem_rsp_ready=0, x9 written; response accepted the next cycle.
REQ-036 Four loads (queue full), then issue plus response in the same cycle -> no hazard_err, count stays 4; a fifth issue without a pop -> hazard_err pulse, entry dropped.
REQ-037 Load to x0 then response 0x55 -> dest_en stays 0, queue empties; alu write x0 -> dest_en=0.
REQ-038 Assert rst_n=0 with 3 pending loads -> outputs at reset values immediately; post-release response -> ready=0, hazard_err pulse.
